// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg
//   Shared types and constants for the fabric configuration loader.
//   - cfg_state_e           : loader FSM states
//   - TILE_*_CHAIN_LEN      : scan-chain lengths of the 8x8 tile
//   - ceil_div()            : integer ceiling division, used for word counts
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_CLB  = 2'd1,
    SHIFT_CONN = 2'd2,
    DONE       = 2'd3
  } cfg_state_e;

  localparam int TILE_CLB_CHAIN_LEN  = 2048;
  localparam int TILE_CONN_CHAIN_LEN = 4096;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_rdback.sv
// cfg_rdback_packer
//   Serial-to-word packer for bits returned from a scan-chain end.
//   Bits are packed LSB-first; a word is emitted when WORD_W bits are
//   collected or when 'last' marks the final bit of a chain, in which case
//   the unfilled high bits are zero. 'clear' drops a partial word silently.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clear             : discard the partial word, suppress any pulse
//   bit_vld, bit_in   : one serial bit per assertion of bit_vld
//   last              : bit_in is the last bit of its chain (flush)
//   chain             : chain id travelling with the word
//   rd_data/rd_valid/rd_chain : packed word, one-cycle pulse, chain id
module cfg_rdback_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_vld,
  input  logic              bit_in,
  input  logic              last,
  input  logic              chain,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_chain
);

  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_nx;
  logic [IDX_W-1:0]  idx_q;

  assign acc_nx = acc_q | (WORD_W'(bit_in) << idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      idx_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_chain <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (bit_vld) begin
        if (last || (idx_q == IDX_LAST)) begin
          rd_data  <= acc_nx;
          rd_chain <= chain;
          rd_valid <= 1'b1;
          acc_q    <= '0;
          idx_q    <= '0;
        end else begin
          acc_q <= acc_nx;
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//   Programs the fabric's CLB scan chain and then its connection scan chain
//   from a word-wide bitstream, one bit per scan_shift strobe (every DIV
//   clocks while a word is buffered). Bits leaving the chain ends are packed
//   into read-back words so the previous configuration is captured.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   start, abort                : begin a load (IDLE/DONE only) / return to IDLE
//   cfg_data, cfg_valid, cfg_ready : bitstream word handshake, LSB first
//   busy, cfg_done              : shifting / load complete (level)
//   clb_scan_en, clb_scan_out   : CLB chain enable and serial data to core
//   conn_scan_en, conn_scan_out : connection chain enable and data to core
//   scan_shift                  : the fabric shifts in this cycle
//   clb_scan_in, conn_scan_in   : chain tail bits returned from core
//   rd_data, rd_valid, rd_chain : read-back word, pulse, source chain
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CLB_CHAIN_LEN  = TILE_CLB_CHAIN_LEN,
  parameter int CONN_CHAIN_LEN = TILE_CONN_CHAIN_LEN,
  parameter int WORD_W         = 8,
  parameter int DIV            = 2,
  parameter int CNT_W          = $clog2(((CLB_CHAIN_LEN > CONN_CHAIN_LEN) ?
                                         CLB_CHAIN_LEN : CONN_CHAIN_LEN) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              busy,
  output logic              cfg_done,
  output logic              clb_scan_en,
  output logic              clb_scan_out,
  output logic              conn_scan_en,
  output logic              conn_scan_out,
  output logic              scan_shift,
  input  logic              clb_scan_in,
  input  logic              conn_scan_in,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_chain
);

  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CLB_LAST  = CNT_W'(CLB_CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_CHAIN_LEN - 1);

  cfg_state_e        state_q;
  cfg_state_e        state_nx;
  logic              busy_q;
  logic              done_q;
  logic              clb_en_q;
  logic              conn_en_q;

  logic [WORD_W-1:0] word_q;
  logic              buf_full_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [BIT_W-1:0]  bit_idx_q;
  logic [CNT_W-1:0]  chain_cnt_q;

  logic              shift_now;
  logic              chain_last;
  logic              chain_end;
  logic              start_ok;
  logic              take;
  logic              scan_bit;

  assign shift_now  = buf_full_q && (div_cnt_q == DIV_LAST);
  assign chain_last = (clb_en_q  && (chain_cnt_q == CLB_LAST)) ||
                      (conn_en_q && (chain_cnt_q == CONN_LAST));
  assign chain_end  = shift_now && chain_last;
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign take       = cfg_valid && cfg_ready;
  // Gated by buf_full so an emptied or stale buffer drives 0.
  assign scan_bit   = buf_full_q && |(word_q & (WORD_W'(1) << bit_idx_q));

  always_comb begin
    state_nx = state_q;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start)     state_nx = SHIFT_CLB;
        SHIFT_CLB:  if (chain_end) state_nx = SHIFT_CONN;
        SHIFT_CONN: if (chain_end) state_nx = DONE;
        default:                   state_nx = IDLE;
      endcase
    end
  end

  // Control stage: state plus registered status/enable outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clb_en_q  <= 1'b0;
      conn_en_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      busy_q    <= (state_nx == SHIFT_CLB) || (state_nx == SHIFT_CONN);
      done_q    <= (state_nx == DONE);
      clb_en_q  <= (state_nx == SHIFT_CLB);
      conn_en_q <= (state_nx == SHIFT_CONN);
    end
  end

  // Word buffer and shift timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q      <= '0;
      buf_full_q  <= 1'b0;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      chain_cnt_q <= '0;
    end else if (abort || start_ok) begin
      word_q      <= '0;
      buf_full_q  <= 1'b0;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      chain_cnt_q <= '0;
    end else if (take) begin
      word_q     <= cfg_data;
      buf_full_q <= 1'b1;
      div_cnt_q  <= '0;
      bit_idx_q  <= '0;
    end else if (buf_full_q) begin
      if (shift_now) begin
        div_cnt_q <= '0;
        if (chain_last) begin
          // Leftover bits of a mid-word chain end are discarded; the next
          // chain always begins on a fresh word.
          buf_full_q  <= 1'b0;
          bit_idx_q   <= '0;
          chain_cnt_q <= '0;
        end else begin
          bit_idx_q   <= bit_idx_q + BIT_W'(1);
          chain_cnt_q <= chain_cnt_q + CNT_W'(1);
          if (bit_idx_q == BIT_LAST) buf_full_q <= 1'b0;
        end
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  cfg_rdback_packer #(
    .WORD_W (WORD_W)
  ) u_rdback (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort || start_ok),
    .bit_vld  (shift_now),
    .bit_in   (clb_en_q ? clb_scan_in : conn_scan_in),
    .last     (chain_last),
    .chain    (conn_en_q),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_chain (rd_chain)
  );

  assign busy          = busy_q;
  assign cfg_done      = done_q;
  assign cfg_ready     = busy_q && !buf_full_q;
  assign clb_scan_en   = clb_en_q;
  assign conn_scan_en  = conn_en_q;
  assign clb_scan_out  = clb_en_q && scan_bit;
  assign conn_scan_out = conn_en_q && scan_bit;
  assign scan_shift    = shift_now;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader
//   Directed bench for fpga_cfg_loader with CLB_LEN=12, CONN_LEN=8,
//   WORD_W=8, DIV=2 and a behavioural model of the two fabric scan chains
//   (tail bit = chain[0], new bit enters at the top on each scan_shift).
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  localparam int CLB_LEN  = 12;
  localparam int CONN_LEN = 8;
  localparam int WW       = 8;
  localparam int DV       = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, busy, cfg_done;
  logic          clb_scan_en, clb_scan_out, conn_scan_en, conn_scan_out;
  logic          scan_shift, clb_scan_in, conn_scan_in;
  logic [WW-1:0] rd_data;
  logic          rd_valid, rd_chain;

  logic [CLB_LEN-1:0]  fab_clb = '0;
  logic [CLB_LEN-1:0]  pre_clb = '0;
  logic [CONN_LEN-1:0] fab_conn = '0;
  logic [CONN_LEN-1:0] pre_conn = '0;
  logic                fab_load = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int         sh_cyc[$];
  logic       sh_clb[$];
  logic       sh_bit[$];
  logic [8:0] rd_q[$];

  logic [17:0] out_vec;
  assign out_vec = {cfg_ready, busy, cfg_done, clb_scan_en, clb_scan_out,
                    conn_scan_en, conn_scan_out, scan_shift, rd_valid,
                    rd_chain, rd_data};

  fpga_cfg_loader #(
    .CLB_CHAIN_LEN  (CLB_LEN),
    .CONN_CHAIN_LEN (CONN_LEN),
    .WORD_W         (WW),
    .DIV            (DV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .busy          (busy),
    .cfg_done      (cfg_done),
    .clb_scan_en   (clb_scan_en),
    .clb_scan_out  (clb_scan_out),
    .conn_scan_en  (conn_scan_en),
    .conn_scan_out (conn_scan_out),
    .scan_shift    (scan_shift),
    .clb_scan_in   (clb_scan_in),
    .conn_scan_in  (conn_scan_in),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_chain      (rd_chain)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fabric scan-chain model
  assign clb_scan_in  = fab_clb[0];
  assign conn_scan_in = fab_conn[0];

  always @(posedge clk) begin
    if (fab_load) begin
      fab_clb  <= pre_clb;
      fab_conn <= pre_conn;
    end else if (scan_shift) begin
      if (clb_scan_en)  fab_clb  <= {clb_scan_out, fab_clb[CLB_LEN-1:1]};
      if (conn_scan_en) fab_conn <= {conn_scan_out, fab_conn[CONN_LEN-1:1]};
    end
  end

  // Strobe and read-back recorder
  always @(negedge clk) begin
    if (scan_shift) begin
      sh_cyc.push_back(cyc);
      sh_clb.push_back(clb_scan_en);
      sh_bit.push_back(clb_scan_en ? clb_scan_out : conn_scan_out);
    end
    if (rd_valid) rd_q.push_back({rd_chain, rd_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [CLB_LEN-1:0] c, input logic [CONN_LEN-1:0] n);
    pre_clb  = c;
    pre_conn = n;
    fab_load = 1'b1;
    @(negedge clk);
    fab_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, output int hs);
    int n;
    n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(n < 100), 1);
    hs = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    while (cfg_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_wait", 32'(n < 400), 1);
    dcyc = cyc;
  endtask

  function automatic logic [31:0] pack_bits(input int s, input int e, input logic want_clb);
    logic [31:0] v;
    int k;
    v = '0;
    k = 0;
    for (int i = s; i < e; i++) begin
      if (sh_clb[i] == want_clb && k < 32) begin
        v[k] = sh_bit[i];
        k++;
      end
    end
    return v;
  endfunction

  function automatic int count_gaps(input int s, input int e, input int g);
    int c;
    c = 0;
    for (int i = s + 1; i < e; i++)
      if (sh_cyc[i] - sh_cyc[i-1] == g) c++;
    return c;
  endfunction

  initial begin
    int hs, tmp, dc, s, e, r, n;
    int stall_bad;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'(out_vec), 0);
    reset = 1'b0;
    preload(12'hABC, 8'h5A);
    check_eq("idle_busy_ready", {30'd0, busy, cfg_ready}, 0);

    // Basic load with read-back of the preloaded fabric
    pulse_start();
    check_eq("start_enables", {28'd0, busy, clb_scan_en, conn_scan_en, cfg_ready}, 4'b1101);
    s = sh_cyc.size();
    r = rd_q.size();
    send_word(8'hA5, hs);
    send_word(8'h3C, tmp);
    send_word(8'hFF, tmp);
    wait_done(dc);
    @(negedge clk);
    e = sh_cyc.size();
    check_eq("t1_strobes", e - s, 20);
    check_eq("t1_first_latency", sh_cyc[s] - hs, DV);
    check_eq("t1_gaps_div", count_gaps(s, e, DV), 17);
    check_eq("t1_gaps_reload", count_gaps(s, e, DV + 1), 2);
    check_eq("t1_clb_bits", pack_bits(s, e, 1'b1), 32'h0CA5);
    check_eq("t1_conn_bits", pack_bits(s, e, 1'b0), 32'h00FF);
    check_eq("t1_done_rise", dc, sh_cyc[e-1] + 1);
    check_eq("t1_done_idle_outs", {27'd0, busy, clb_scan_en, conn_scan_en, cfg_ready, scan_shift}, 0);
    check_eq("t1_done_level", 32'(cfg_done), 1);
    check_eq("t1_fab_clb", 32'(fab_clb), 32'h0CA5);
    check_eq("t1_fab_conn", 32'(fab_conn), 32'h00FF);
    check_eq("t2_rd_count", rd_q.size() - r, ceil_div(CLB_LEN, WW) + ceil_div(CONN_LEN, WW));
    check_eq("t2_rd_word0", 32'(rd_q[r]), 32'h0BC);
    check_eq("t2_rd_word1", 32'(rd_q[r+1]), 32'h00A);
    check_eq("t2_rd_word2", 32'(rd_q[r+2]), 32'h15A);

    // Restart from DONE, stall mid-load, start ignored while busy
    pulse_start();
    check_eq("t5_restart", {30'd0, cfg_done, busy}, 2'b01);
    s = sh_cyc.size();
    send_word(8'hA5, hs);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_empty_wait", 32'(n < 50), 1);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (scan_shift || !clb_scan_en) stall_bad++;
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("t3_stall_quiet", stall_bad, 0);
    send_word(8'h3C, tmp);
    send_word(8'hFF, tmp);
    wait_done(dc);
    @(negedge clk);
    e = sh_cyc.size();
    check_eq("t3_strobes", e - s, 20);
    check_eq("t3_clb_bits", pack_bits(s, e, 1'b1), 32'h0CA5);
    check_eq("t3_conn_bits", pack_bits(s, e, 1'b0), 32'h00FF);
    check_eq("t3_gaps_div", count_gaps(s, e, DV), 17);

    // Abort after five shifts, then a clean reload
    pulse_start();
    r = rd_q.size();
    send_word(8'hA5, hs);
    n = 0;
    tmp = 0;
    while (tmp < 5 && n < 100) begin
      if (scan_shift) tmp++;
      @(negedge clk);
      n++;
    end
    check_eq("t4_five_shifts", tmp, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t4_abort_outs", {27'd0, busy, clb_scan_en, conn_scan_en, cfg_ready, rd_valid}, 0);
    s = sh_cyc.size();
    repeat (20) @(negedge clk);
    check_eq("t4_no_rd_after_abort", rd_q.size() - r, 0);
    check_eq("t4_no_shift_idle", sh_cyc.size() - s, 0);
    preload(12'h123, 8'hC3);
    pulse_start();
    s = sh_cyc.size();
    r = rd_q.size();
    send_word(8'hA5, hs);
    send_word(8'h3C, tmp);
    send_word(8'hFF, tmp);
    wait_done(dc);
    @(negedge clk);
    e = sh_cyc.size();
    check_eq("t4_reload_clb_bits", pack_bits(s, e, 1'b1), 32'h0CA5);
    check_eq("t4_reload_conn_bits", pack_bits(s, e, 1'b0), 32'h00FF);
    check_eq("t4_rd_count", rd_q.size() - r, 3);
    check_eq("t4_rd_word0", 32'(rd_q[r]), 32'h023);
    check_eq("t4_rd_word1", 32'(rd_q[r+1]), 32'h001);
    check_eq("t4_rd_word2", 32'(rd_q[r+2]), 32'h1C3);

    // Asynchronous reset in the middle of the connection chain
    pulse_start();
    send_word(8'hA5, tmp);
    send_word(8'h3C, tmp);
    send_word(8'hFF, tmp);
    repeat (3) @(negedge clk);
    check_eq("t6_in_conn", {30'd0, conn_scan_en, busy}, 2'b11);
    #2 reset = 1'b1;
    #1 check_eq("t6_async_clear", 32'(out_vec), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_idle_after", {29'd0, busy, cfg_done, cfg_ready}, 0);
    pulse_start();
    check_eq("t6_start_from_idle", {30'd0, busy, clb_scan_en}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
